// File: rtl/grid_assemble.sv
// grid_assemble: rebuilds the N x N board (TILE_W-bit tile codes, row-major) from N processed
// lines delivered one at a time by the line-merge unit, and flags whether the move changed
// the board.
//
// Ports:
//   i_clk, i_rst_n       clock (rising edge), asynchronous active-low reset
//   i_start, i_rc        begin assembly; i_rc=1 lines are rows, 0 lines are columns
//   i_old_grid           pre-move board, latched with i_start
//   i_line_valid/_data   incoming processed line, lines 0..N-1 in order
//   o_line_ready         a line is accepted this cycle when i_line_valid is also high
//   o_grid_out           assembled board, only ever updated with a complete board
//   o_grid_valid         o_grid_out and o_changed are valid; held until i_grid_ack
//   o_changed            o_grid_out differs from the latched old board
//   o_busy               block is not idle
module grid_assemble #(
  parameter int unsigned TILE_W = 3,
  parameter int unsigned N      = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_rc,
  input  logic [N*N*TILE_W-1:0]     i_old_grid,
  input  logic                      i_line_valid,
  input  logic [N*TILE_W-1:0]       i_line_data,
  output logic                      o_line_ready,
  output logic [N*N*TILE_W-1:0]     o_grid_out,
  output logic                      o_grid_valid,
  input  logic                      i_grid_ack,
  output logic                      o_changed,
  output logic                      o_busy
);

  localparam int unsigned GRID_W = N * N * TILE_W;
  localparam int unsigned LINE_W = N * TILE_W;
  localparam int unsigned CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LastLine = CNT_W'(N - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rc;
  logic [GRID_W-1:0]   r_old;
  logic [GRID_W-1:0]   r_work;
  logic [GRID_W-1:0]   r_grid_out;
  logic                r_line_ready;
  logic                r_grid_valid;
  logic                r_changed;
  logic                r_busy;

  logic                w_accept;
  logic [GRID_W-1:0]   w_grid_wr;

  // r_line_ready is high exactly while collecting, so it doubles as the accept qualifier.
  assign w_accept = r_line_ready && i_line_valid;

  // Working grid with the current line merged in at the position selected by r_cnt.
  always_comb begin
    w_grid_wr = r_work;
    if (r_rc) begin
      w_grid_wr[int'(r_cnt) * LINE_W +: LINE_W] = i_line_data;
    end else begin
      // Column line: its most significant tile belongs to row 0.
      for (int r = 0; r < int'(N); r++) begin
        w_grid_wr[r * LINE_W + int'(r_cnt) * TILE_W +: TILE_W] =
            i_line_data[(int'(N) - 1 - r) * TILE_W +: TILE_W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_rc         <= 1'b0;
      r_old        <= '0;
      r_work       <= '0;
      r_grid_out   <= '0;
      r_line_ready <= 1'b0;
      r_grid_valid <= 1'b0;
      r_changed    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_rc         <= i_rc;
            r_old        <= i_old_grid;
            r_cnt        <= '0;
            r_work       <= '0;
            r_line_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= StCollect;
          end
        end
        StCollect: begin
          if (w_accept) begin
            r_work <= w_grid_wr;
            if (r_cnt == LastLine) begin
              // Publish the whole board at once so o_grid_out never shows a partial board.
              r_grid_out   <= w_grid_wr;
              r_changed    <= (w_grid_wr != r_old);
              r_grid_valid <= 1'b1;
              r_line_ready <= 1'b0;
              r_state      <= StDone;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        StDone: begin
          if (i_grid_ack) begin
            r_grid_valid <= 1'b0;
            r_changed    <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= StIdle;
          end
        end
        default: begin
          r_state      <= StIdle;
          r_line_ready <= 1'b0;
          r_grid_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign o_line_ready = r_line_ready;
  assign o_grid_out   = r_grid_out;
  assign o_grid_valid = r_grid_valid;
  assign o_changed    = r_changed;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_grid_assemble.sv
// Bench for grid_assemble: directed scenarios plus randomized assemblies, all checked against
// a tile-array reference model of the board.
module tb_grid_assemble;

  localparam int TW = 3;
  localparam int NN = 3;
  localparam int LW = NN * TW;
  localparam int GW = NN * NN * TW;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_rc = 1'b0;
  logic [GW-1:0] i_old_grid = '0;
  logic          i_line_valid = 1'b0;
  logic [LW-1:0] i_line_data = '0;
  logic          o_line_ready;
  logic [GW-1:0] o_grid_out;
  logic          o_grid_valid;
  logic          i_grid_ack = 1'b0;
  logic          o_changed;
  logic          o_busy;

  int n_total = 0;
  int n_bad   = 0;

  grid_assemble #(.TILE_W(TW), .N(NN)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_rc         (i_rc),
    .i_old_grid   (i_old_grid),
    .i_line_valid (i_line_valid),
    .i_line_data  (i_line_data),
    .o_line_ready (o_line_ready),
    .o_grid_out   (o_grid_out),
    .o_grid_valid (o_grid_valid),
    .i_grid_ack   (i_grid_ack),
    .o_changed    (o_changed),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no end, wanted finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference model: place tiles on a 2-D board, then pack row-major (row r, position p at
  // bit offset r*LW + p*TW).
  function automatic logic [GW-1:0] model_grid(input logic rc, input logic [GW-1:0] lines);
    logic [TW-1:0] tiles [NN][NN];
    logic [GW-1:0] g;
    for (int k = 0; k < NN; k++) begin
      for (int i = 0; i < NN; i++) begin
        logic [TW-1:0] t;
        t = lines[k*LW + i*TW +: TW];
        if (rc) tiles[k][i] = t;          // line k is row k, tile i at position i
        else    tiles[NN-1-i][k] = t;     // line k is column k, tile i lands in row N-1-i
      end
    end
    g = '0;
    for (int r = 0; r < NN; r++)
      for (int p = 0; p < NN; p++)
        g[r*LW + p*TW +: TW] = tiles[r][p];
    return g;
  endfunction

  task automatic do_start(input string tag, input logic rc, input logic [GW-1:0] old);
    i_start = 1'b1; i_rc = rc; i_old_grid = old;
    step();
    i_start = 1'b0; i_rc = $urandom; i_old_grid = {$urandom, $urandom};
    check_eq({tag, ".ready_after_start"}, 32'(o_line_ready), 32'd1);
    check_eq({tag, ".busy_after_start"}, 32'(o_busy), 32'd1);
  endtask

  task automatic send_line(input string tag, input logic [LW-1:0] d, input int gap);
    for (int g = 0; g < gap; g++) begin
      i_line_valid = 1'b0; i_line_data = LW'($urandom);
      step();
    end
    check_eq({tag, ".ready_before_line"}, 32'(o_line_ready), 32'd1);
    i_line_valid = 1'b1; i_line_data = d;
    step();
    i_line_valid = 1'b0; i_line_data = LW'($urandom);
  endtask

  task automatic collect(input string tag, input logic rc, input logic [GW-1:0] old,
                         input logic [GW-1:0] lines, input int g0, input int g1, input int g2);
    logic [GW-1:0] exp;
    exp = model_grid(rc, lines);
    send_line(tag, lines[0 +: LW], g0);
    check_eq({tag, ".no_valid_early"}, 32'(o_grid_valid), 32'd0);
    send_line(tag, lines[LW +: LW], g1);
    send_line(tag, lines[2*LW +: LW], g2);
    check_eq({tag, ".grid_valid"}, 32'(o_grid_valid), 32'd1);
    check_eq({tag, ".ready_low_done"}, 32'(o_line_ready), 32'd0);
    check_eq({tag, ".grid_out"}, 32'(o_grid_out), 32'(exp));
    check_eq({tag, ".changed"}, 32'(o_changed), 32'(exp != old));
  endtask

  task automatic ack_done(input string tag);
    i_grid_ack = 1'b1;
    step();
    i_grid_ack = 1'b0;
    check_eq({tag, ".valid_after_ack"}, 32'(o_grid_valid), 32'd0);
    check_eq({tag, ".busy_after_ack"}, 32'(o_busy), 32'd0);
  endtask

  task automatic assemble(input string tag, input logic rc, input logic [GW-1:0] old,
                          input logic [GW-1:0] lines, input int g0, input int g1, input int g2);
    do_start(tag, rc, old);
    collect(tag, rc, old, lines, g0, g1, g2);
    ack_done(tag);
  endtask

  logic [GW-1:0] dir_lines;
  logic [GW-1:0] row_res;
  logic [GW-1:0] held;
  logic [GW-1:0] exp_g;

  initial begin
    dir_lines = {9'o701, 9'o456, 9'o123};
    row_res   = 27'o701456123;

    // Reset state
    #3;
    check_eq("rst.ready", 32'(o_line_ready), 32'd0);
    check_eq("rst.valid", 32'(o_grid_valid), 32'd0);
    check_eq("rst.changed", 32'(o_changed), 32'd0);
    check_eq("rst.busy", 32'(o_busy), 32'd0);
    check_eq("rst.grid", 32'(o_grid_out), 32'd0);
    step();
    i_rst_n = 1'b1;
    step();

    // Directed: known board values
    check_eq("model.rows", 32'(model_grid(1'b1, dir_lines)), 32'(row_res));
    check_eq("model.cols", 32'(model_grid(1'b0, dir_lines)), 32'(27'o163052741));
    assemble("row", 1'b1, '0, dir_lines, 0, 0, 0);
    assemble("col", 1'b0, '0, dir_lines, 0, 0, 0);
    assemble("nochg", 1'b1, row_res, dir_lines, 0, 0, 0);

    // Gaps in line_valid: 1 high, 3 low, 1 high, 2 low, 1 high
    assemble("gaps", 1'b1, '0, dir_lines, 0, 3, 2);

    // line_valid pulses in IDLE must not disturb anything
    held = o_grid_out;
    for (int c = 0; c < 3; c++) begin
      i_line_valid = 1'b1; i_line_data = LW'($urandom);
      step();
      check_eq("idle_lv.grid", 32'(o_grid_out), 32'(held));
      check_eq("idle_lv.busy", 32'(o_busy), 32'd0);
    end
    i_line_valid = 1'b0;

    // start while busy is ignored; then a held DONE with line_valid noise stays stable
    do_start("sbusy", 1'b1, '0);
    send_line("sbusy", dir_lines[0 +: LW], 0);
    i_start = 1'b1; i_rc = 1'b0; i_old_grid = row_res;
    step();
    i_start = 1'b0;
    check_eq("sbusy.busy", 32'(o_busy), 32'd1);
    send_line("sbusy", dir_lines[LW +: LW], 0);
    send_line("sbusy", dir_lines[2*LW +: LW], 0);
    check_eq("sbusy.grid", 32'(o_grid_out), 32'(row_res));
    check_eq("sbusy.changed", 32'(o_changed), 32'd1);
    for (int c = 0; c < 5; c++) begin
      i_line_valid = 1'($urandom); i_line_data = LW'($urandom);
      step();
      check_eq("hold.valid", 32'(o_grid_valid), 32'd1);
      check_eq("hold.grid", 32'(o_grid_out), 32'(row_res));
      check_eq("hold.changed", 32'(o_changed), 32'd1);
    end
    i_line_valid = 1'b0;

    // ack and start together in DONE: back to IDLE only
    i_grid_ack = 1'b1; i_start = 1'b1; i_rc = 1'b0;
    step();
    i_grid_ack = 1'b0; i_start = 1'b0;
    check_eq("ackstart.valid", 32'(o_grid_valid), 32'd0);
    check_eq("ackstart.busy", 32'(o_busy), 32'd0);
    step();
    check_eq("ackstart.still_idle", 32'(o_busy), 32'd0);

    // Asynchronous reset mid-COLLECT
    do_start("rstmid", 1'b0, 27'o777777777);
    send_line("rstmid", 9'o777, 0);
    send_line("rstmid", 9'o555, 0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("rstmid.ready", 32'(o_line_ready), 32'd0);
    check_eq("rstmid.busy", 32'(o_busy), 32'd0);
    check_eq("rstmid.valid", 32'(o_grid_valid), 32'd0);
    check_eq("rstmid.grid", 32'(o_grid_out), 32'd0);
    step();
    i_rst_n = 1'b1;
    step();
    assemble("after_rst", 1'b1, '0, dir_lines, 0, 0, 0);
    assemble("after_rst_col", 1'b0, '0, {9'o000, 9'o000, 9'o001}, 1, 0, 0);

    // Randomized assemblies
    for (int it = 0; it < 40; it++) begin
      logic          rc;
      logic [GW-1:0] lines;
      logic [GW-1:0] old;
      rc    = 1'($urandom);
      lines = GW'({$urandom, $urandom});
      exp_g = model_grid(rc, lines);
      old   = ($urandom_range(0, 3) == 0) ? exp_g : GW'({$urandom, $urandom});
      assemble("rand", rc, old, lines, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/grid_assemble.md
Name: grid_assemble

Overview:
- Sequential inverse of the line-extraction path: takes the three processed 9-bit lines produced by the slide/merge logic and rebuilds the 27-bit 3x3 board (3-bit tile codes).
- Lines are either rows or columns of the board. Column lines are transposed back into row-major board order.
- Sits between the line-merge unit and the board register.
- Also reports whether the move changed the board, so the game FSM can decide whether to spawn a tile.

Parameters:
- TILE_W, 3, bits per tile code.
- N, 3, board dimension (tiles per line, lines per board). GRID_W = N*N*TILE_W and LINE_W = N*TILE_W are derived, not overridable.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin assembly; sampled only in IDLE
- rc  in  1  line orientation, sampled with start: 1 = lines are rows, 0 = lines are columns
- old_grid  in  GRID_W  pre-move board, sampled with start
- line_valid  in  1  line_data valid
- line_data  in  LINE_W  processed line; lines arrive in order 0..N-1
- line_ready  out  1  block accepts a line this cycle
- grid_out  out  GRID_W  assembled board (registered)
- grid_valid  out  1  grid_out and changed are valid
- grid_ack  in  1  consumer accepts the result
- changed  out  1  grid_out differs from latched old_grid
- busy  out  1  block is not in IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; line_ready, grid_valid, changed and busy are 0; grid_out, the line counter and the latched rc/old_grid are all 0.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - start=1 latches rc and old_grid, clears the line counter to 0, and moves to COLLECT.
  - grid_out keeps its last assembled value.
- COLLECT:
  - line_ready=1 and busy=1.
  - A line is accepted on any cycle with line_valid && line_ready. Accepting a line writes it into the working grid and increments the counter.
  - Accepting line N-1 moves to DONE on the next edge.
  - Gaps in line_valid stall the block indefinitely, with no timeout.
- Write mapping for line k, with r being the row index and i the tile index within a line, r and i in 0..N-1:
  - rc=1 (rows): grid[k*LINE_W +: LINE_W] = line_data.
  - rc=0 (columns): grid[r*LINE_W + k*TILE_W +: TILE_W] = line_data[(N-1-r)*TILE_W +: TILE_W]. The line's MSB tile is row 0.
- DONE:
  - grid_valid=1 and busy=1; line_ready=0.
  - grid_out holds the full new board and changed = (grid_out != old_grid). Both are stable while grid_valid=1.
  - grid_ack=1 moves to IDLE on the next edge, with grid_valid falling that edge.
  - grid_ack is ignored outside DONE.
- Working grid:
  - Starts each assembly from 0.
  - Is copied to grid_out at the same edge the block enters DONE.
  - grid_out never shows a partial board.
- Latency:
  - start at edge t gives line_ready=1 from cycle t+1.
  - Final line accepted at edge t gives grid_valid=1 in cycle t+1.
  - Minimum start-to-grid_valid is N+1 cycles.
- start while busy is ignored: no relatch and no restart.
- line_valid outside COLLECT is ignored; no line is consumed.
- The line counter never exceeds N-1. There is no wrap, because leaving COLLECT is forced at count N-1.
- grid_ack and start in the same cycle in DONE: return to IDLE only. start is not honoured until IDLE.
- rst_n asserted mid-COLLECT or mid-DONE: immediate return to IDLE with all outputs at reset values. The partial board is discarded.

Test Plan:
- Row mode:
  - Stimulus: start with rc=1, old_grid=0, then lines 9'o123, 9'o456, 9'o701 on consecutive cycles.
  - Required: grid_valid in the cycle after line 2, grid_out=27'o701456123, changed=1; after grid_ack, busy=0 next cycle.
- Column mode:
  - Stimulus: start with rc=0, then lines 9'o123, 9'o456, 9'o701.
  - Required: grid_out=27'o163052741 (row0=9'o741, row1=9'o052, row2=9'o163), changed=1.
- No-change detection:
  - Stimulus: rc=1, old_grid=27'o701456123, same three row lines.
  - Required: grid_out=27'o701456123, changed=0.
- Backpressure and idle gaps:
  - Stimulus: line_valid high for 1 cycle, low for 3, high, low 2, high.
  - Required: exactly 3 lines accepted and the same result as the row-mode test.
  - Also: line_valid pulses while in IDLE or DONE leave grid_out unchanged.
- Start while busy:
  - Stimulus: in COLLECT after 1 line, pulse start with rc=0 and a new old_grid.
  - Required: ignored; the result uses the original rc and old_grid.
  - Also: with grid_valid held and grid_ack withheld for 5 cycles, grid_out and changed stay stable.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously after 2 lines accepted.
  - Required: outputs go to 0 immediately without a clock edge.
  - After release: a fresh start with 3 lines produces the correct board, with no leftover data from the aborted assembly.
